serial_subtractor: RTL

//  - Bit-serial, LSB-first subtractor: computes a - b one bit per clock with a registered borrow.
//  - Counterpart of the combinational half/full-adder blocks. It performs the inverse operation

---
 rtl/serial_subtractor_if.sv | 32 +++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
// master drives the request side, slave (the subtractor) drives status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b subtractor with registered borrow; SERIAL_SUB_OVF_EN adds signed ovf.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored (not queued) while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] res_next;

    assign bit_d    = a_q[0] ^ b_q[0] ^ brw_q;
    assign bit_bo   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    // Shift the new difference bit in at the MSB; works for WIDTH=1 as well.
    assign res_next = WIDTH'({bit_d, res_q} >> 1);

`ifdef SERIAL_SUB_OVF_EN
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    res_d   = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    // Operand MSBs are shifted away during RUN, so keep them for ovf.
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = bus.b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next;
                brw_d = bit_bo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    diff_d   = res_next;
                    borrow_d = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (amsb_q != bmsb_q) && (res_next[WIDTH-1] != amsb_q);
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule
